// File: rtl/seq_mult_pkg.sv
// +----------------------------------------------------------------------+
// | seq_mult_pkg : shared state type and defaults for the shift-add mult  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package seq_mult_pkg;

  localparam int SEQ_MULT_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_mult_state_e;

endpackage

`default_nettype wire

// File: rtl/seq_mult_ctrl.sv
// +----------------------------------------------------------------------+
// | seq_mult_ctrl : IDLE/RUN/DONE sequencer issuing load/step/finish      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_mult_ctrl
  import seq_mult_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic last,
  output logic load,
  output logic step,
  output logic finish,
  output logic busy,
  output logic done
);

  seq_mult_state_e r_state;
  seq_mult_state_e w_state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    load        = 1'b0;
    step        = 1'b0;
    finish      = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          load        = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          finish      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // start is deliberately ignored here; restart happens from IDLE
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seq_mult.sv
// +----------------------------------------------------------------------+
// | seq_mult : radix-2 sequential multiplier, optional signed operands.   |
// | Option macro SEQ_MULT_EARLY_DONE_EN stops once the multiplier is 0.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH  = SEQ_MULT_DEFAULT_WIDTH,
  parameter bit SIGNED = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int               c_CNT_W     = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_product;
  logic [WIDTH-1:0]   r_mplier;
  logic [c_CNT_W-1:0] r_count;
  logic               r_neg;

  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0]   w_mplier_nxt;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_neg;
  logic               w_last;
  logic               w_load;
  logic               w_step;
  logic               w_finish;

  // Negating the most-negative value wraps back to 2^(WIDTH-1), which is
  // exactly the unsigned magnitude we need.
  generate
    if (SIGNED) begin : g_signed
      assign w_mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
      assign w_mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;
      assign w_neg   = a[WIDTH-1] ^ b[WIDTH-1];
    end else begin : g_unsigned
      assign w_mag_a = a;
      assign w_mag_b = b;
      assign w_neg   = 1'b0;
    end
  endgenerate

  assign w_acc_nxt    = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mplier_nxt = r_mplier >> 1;

`ifdef SEQ_MULT_EARLY_DONE_EN
  assign w_last = (w_mplier_nxt == '0) || (r_count == c_LAST_STEP);
`else
  assign w_last = (r_count == c_LAST_STEP);
`endif

  seq_mult_ctrl u_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .last   (w_last),
    .load   (w_load),
    .step   (w_step),
    .finish (w_finish),
    .busy   (busy),
    .done   (done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mplier  <= '0;
      r_count   <= '0;
      r_neg     <= 1'b0;
      r_product <= '0;
    end else begin
      if (w_load) begin
        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
        r_mplier <= w_mag_b;
        r_acc    <= '0;
        r_count  <= '0;
        r_neg    <= w_neg;
      end
      if (w_step) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= w_mplier_nxt;
        r_count  <= r_count + 1'b1;
      end
      // The final step's sum is folded in here so product is valid with done.
      if (w_finish) begin
        r_product <= r_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
      end
    end
  end

  assign product = r_product;

endmodule

`default_nettype wire

// File: tb/tb_seq_mult.sv
// +----------------------------------------------------------------------+
// | tb_seq_mult : scoreboard bench for unsigned and signed seq_mult       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_seq_mult;

  localparam int W = 16;
`ifdef SEQ_MULT_EARLY_DONE_EN
  localparam bit c_EARLY = 1'b1;
`else
  localparam bit c_EARLY = 1'b0;
`endif

  typedef struct {
    logic [2*W-1:0] prod;
    int             acc_cyc;
    int             lat;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start_u = 1'b0, start_s = 1'b0;
  logic [W-1:0]   a_u = '0, b_u = '0, a_s = '0, b_s = '0;
  logic           busy_u, done_u, busy_s, done_s;
  logic [2*W-1:0] prod_u, prod_s;

  exp_t           q_u[$];
  exp_t           q_s[$];
  exp_t           e_u, e_s;
  logic [2*W-1:0] last_u = '0;
  int             cyc = 0;
  int             n_cmp = 0;
  int             n_err = 0;

  seq_mult #(.WIDTH(W), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .start(start_u), .a(a_u), .b(b_u),
    .busy(busy_u), .done(done_u), .product(prod_u)
  );

  seq_mult #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .a(a_s), .b(b_s),
    .busy(busy_s), .done(done_s), .product(prod_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(input logic [W-1:0] mb);
    int k = 1;
    for (int i = 0; i < W; i++) if (mb[i]) k = i + 1;
    return c_EARLY ? k : W;
  endfunction

  function automatic exp_t make_exp(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint x, y, ay;
    x = sgn ? longint'($signed(a)) : longint'({1'b0, a});
    y = sgn ? longint'($signed(b)) : longint'({1'b0, b});
    ay = (y < 0) ? -y : y;
    e.prod    = (2*W)'(x * y);
    e.lat     = lat_of(W'(ay));
    e.acc_cyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done_u) begin
      if (q_u.size() == 0) chk("u_spurious_done", 1, 0);
      else begin
        e_u = q_u.pop_front();
        chk("u_product", prod_u, e_u.prod);
        chk("u_latency", cyc - e_u.acc_cyc, e_u.lat);
        last_u = e_u.prod;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done_s) begin
      if (q_s.size() == 0) chk("s_spurious_done", 1, 0);
      else begin
        e_s = q_s.pop_front();
        chk("s_product", prod_s, e_s.prod);
        chk("s_latency", cyc - e_s.acc_cyc, e_s.lat);
      end
    end
  end

  // Waits for idle, drives one request and checks busy rises after acceptance.
  task automatic issue(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while ((sgn ? busy_s : busy_u) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("idle_timeout", 0, 1);
    e = make_exp(sgn, a, b);
    e.acc_cyc = cyc + 1;
    if (sgn) begin
      a_s = a; b_s = b; start_s = 1'b1; q_s.push_back(e);
    end else begin
      a_u = a; b_u = b; start_u = 1'b1; q_u.push_back(e);
    end
    @(negedge clk);
    start_u = 1'b0;
    start_s = 1'b0;
    a_u = W'($urandom);
    b_u = W'($urandom);
    a_s = W'($urandom);
    b_s = W'($urandom);
    chk(sgn ? "s_busy" : "u_busy", sgn ? busy_s : busy_u, 1);
  endtask

  task automatic drain();
    int guard = 0;
    while ((q_u.size() != 0 || q_s.size() != 0 || busy_u || busy_s) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) chk("drain_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int guard;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_u, 0);
    chk("rst_done", done_u, 0);
    chk("rst_product", prod_u, 0);
    chk("rst_product_s", prod_s, 0);
    rst_n = 1'b1;

    issue(0, 16'd3, 16'd5);
    issue(0, 16'hFFFF, 16'hFFFF);
    issue(1, -16'sd3, 16'sd7);
    drain();
    chk("u_hold", prod_u, last_u);
    issue(1, 16'h8000, 16'h8000);
    issue(0, 16'd9, 16'd1);
    issue(0, 16'd5, 16'd0);
    for (int i = 0; i < 3; i++) begin
      issue(0, W'($urandom), W'($urandom));
      issue(1, W'($urandom), W'($urandom));
    end
    drain();

    // start pulses during RUN and during DONE must both be dropped
    issue(0, 16'd100, 16'd200);
    repeat (4) @(negedge clk);
    a_u = 16'd7; b_u = 16'd7; start_u = 1'b1;
    @(negedge clk);
    start_u = 1'b0;
    guard = 0;
    while (!done_u && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("done_wait_timeout", 0, 1);
    a_u = 16'd11; b_u = 16'd13; start_u = 1'b1;
    @(negedge clk);
    start_u = 1'b0;
    repeat (25) @(negedge clk);
    drain();

    // continuous start: back-to-back ops with one idle cycle between
    a_u = 16'd21; b_u = 16'h00F3;
    e_u = make_exp(0, a_u, b_u);
    a0 = cyc + 1;
    e_u.acc_cyc = a0;
    q_u.push_back(e_u);
    e_u.acc_cyc = a0 + e_u.lat + 2;
    q_u.push_back(e_u);
    start_u = 1'b1;
    guard = 0;
    while (cyc < a0 + e_u.lat + 2 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (cyc == a0 + e_u.lat + 1) chk("u_idle_gap", busy_u, 0);
    end
    start_u = 1'b0;
    drain();

    // reset mid-run aborts without a done
    issue(0, 16'h1234, 16'h0F0F);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy_u, 0);
    chk("abort_done", done_u, 0);
    chk("abort_product", prod_u, 0);
    q_u.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(0, 16'd2, 16'd2);
    drain();
    chk("post_abort_product", prod_u, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; legal range 2..32.
REQ-002 Parameter SIGNED, default 0: 0 = unsigned operands, 1 = two's-complement operands.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 a  input  WIDTH  multiplicand; captured on the edge that accepts start.
REQ-007 b  input  WIDTH  multiplier; captured on the edge that accepts start.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  single-cycle pulse; product valid.
REQ-010 product  output  2*WIDTH  registered result; holds until the next completion or reset.

Function
REQ-011 FSM states: IDLE, RUN, DONE. IDLE->RUN on start=1; RUN->DONE on the exit condition; DONE->IDLE unconditionally after one cycle.
REQ-012 Accept edge E0 (IDLE, start=1) loads these values:
- multiplicand register (2*WIDTH wide) <- |a|;
- multiplier register <- |b|;
- accumulator <- 0;
- step counter <- 0;
- result sign <- sign(a) XOR sign(b), forced to 0 when SIGNED=0.
REQ-013 Each RUN edge performs one radix-2 shift-add step:
- if multiplier[0]=1, accumulator += multiplicand;
- multiplicand <<= 1;
- multiplier >>= 1;
- counter += 1.
REQ-014 RUN exit without early termination: exactly WIDTH steps (edges E1..E_WIDTH). done is high in the cycle after E_WIDTH, which is WIDTH cycles after E0.
REQ-015 On entry to DONE, product <- accumulator, two's-complement negated when result sign=1. done=1 for exactly that one cycle.
REQ-016 Arithmetic wraps modulo 2^(2*WIDTH); the unsigned product never overflows.
REQ-017 Magnitude of the most-negative operand (-2^(WIDTH-1)) is taken as the unsigned value 2^(WIDTH-1); the result is exact.
REQ-018 start while busy=1 is ignored, including in DONE. Operands may change freely after E0 without effect.
REQ-019 start held high continuously restarts in the IDLE cycle following DONE. There is one idle cycle between operations.

Reset
REQ-020 rst_n low at any time, including mid-RUN, immediately forces:
- state IDLE;
- busy=0, done=0, product=0;
- all internal registers 0.
REQ-021 The first start after rst_n deasserts is accepted normally; an aborted operation produces no done.

Configuration
REQ-022 Macro SEQ_MULT_EARLY_DONE_EN defined: RUN exits at the edge on which the post-shift multiplier register becomes zero. Step count k = max(1, index of highest set bit of |b| + 1); done appears k cycles after E0.
REQ-023 Macro undefined: fixed latency per REQ-014 for all operands.
REQ-024 Product values are identical with and without the macro.

Structure
REQ-025 Package seq_mult_pkg holds:
- the FSM state typedef (IDLE, RUN, DONE);
- constant SEQ_MULT_DEFAULT_WIDTH = 16.
REQ-026 The FSM is sub-module seq_mult_ctrl. It outputs load, step and finish strobes plus busy/done. The datapath registers stay in seq_mult.

Verification
REQ-027 WIDTH=16, SIGNED=0, macro off: a=3, b=5, start -> busy high; done pulse 16 cycles after acceptance; product=32'h0000000F.
REQ-028 WIDTH=16, SIGNED=0: a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE0001.
REQ-029 WIDTH=16, SIGNED=1, in two separate runs:
- a=-3, b=7 -> product=32'hFFFFFFEB;
- a=16'h8000, b=16'h8000 -> product=32'h40000000.
REQ-030 Start pulsed at cycle 5 of a busy operation with different operands -> ignored; exactly one done; first operation's result.
REQ-031 rst_n low at RUN step 8 -> busy=0, product=0, no done; a new start (a=2, b=2) -> product=4.
REQ-032 Macro on, WIDTH=16, in two separate runs:
- b=0 -> done 1 cycle after acceptance, product=0;
- b=1, a=9 -> done 1 cycle after acceptance, product=9.
